// File: rtl/vga_rect_fill_buffer_if.sv
// Command and VGA read-port bundle for the rectangle-fill character frame buffer.
interface vga_rect_fill_buffer_if;
    logic       iCmdValid;
    logic [6:0] iX0;
    logic [5:0] iY0;
    logic [6:0] iX1;
    logic [5:0] iY1;
    logic [2:0] iColor;
    logic       oBusy;
    logic [9:0] iColumn;
    logic [9:0] iRow;
    logic [2:0] oPixel;

    modport master (
        output iCmdValid, iX0, iY0, iX1, iY1, iColor, iColumn, iRow,
        input  oBusy, oPixel
    );

    modport slave (
        input  iCmdValid, iX0, iY0, iX1, iY1, iColor, iColumn, iRow,
        output oBusy, oPixel
    );
endinterface

// File: rtl/vga_rect_fill_buffer.sv
// 80x60-cell, 3-bit colour frame buffer: a fill engine writes rectangles one cell per cycle
// while the VGA side reads the cell under the current pixel with a two-cycle latency.
module vga_rect_fill_buffer (
    input logic                   Clock,
    input logic                   Reset,
    vga_rect_fill_buffer_if.slave bus
);
    localparam int unsigned Cols  = 80;
    localparam int unsigned Cells = 4800;

    typedef enum logic [1:0] {StClear, StIdle, StFill, StSkip} fillStateT;

    fillStateT   stateQ, stateD;
    logic [12:0] clrAddrQ, clrAddrD;
    logic [6:0]  xQ, xD, x0Q, x0D, x1Q, x1D;
    logic [5:0]  yQ, yD, y1Q, y1D;
    logic [2:0]  colorQ, colorD;

    logic        wrEn;
    logic [12:0] wrAddr;
    logic [2:0]  wrData;
    logic [12:0] fillAddr;

    logic [6:0]  x1Clamp;
    logic [5:0]  y1Clamp;
    logic        cmdEmpty;

    logic [2:0]  mem [Cells];

    // y*80 + x built from shifts so no multiplier is inferred
    assign fillAddr = 13'({yQ, 6'b0}) + 13'({yQ, 4'b0}) + 13'(xQ);

    assign x1Clamp  = (bus.iX1 > 7'(Cols - 1)) ? 7'(Cols - 1) : bus.iX1;
    assign y1Clamp  = (bus.iY1 > 6'd59) ? 6'd59 : bus.iY1;
    assign cmdEmpty = (bus.iX0 > 7'(Cols - 1)) || (bus.iY0 > 6'd59) ||
                      (bus.iX0 > x1Clamp) || (bus.iY0 > y1Clamp);

    assign bus.oBusy = (stateQ != StIdle);

    always_comb begin
        stateD   = stateQ;
        clrAddrD = clrAddrQ;
        xD       = xQ;
        x0D      = x0Q;
        x1D      = x1Q;
        yD       = yQ;
        y1D      = y1Q;
        colorD   = colorQ;
        wrEn     = 1'b0;
        wrAddr   = fillAddr;
        wrData   = colorQ;

        case (stateQ)
            StClear: begin
                wrEn   = 1'b1;
                wrAddr = clrAddrQ;
                wrData = 3'b000;
                if (clrAddrQ == 13'(Cells - 1)) begin
                    stateD = StIdle;
                end else begin
                    clrAddrD = clrAddrQ + 13'd1;
                end
            end
            StIdle: begin
                if (bus.iCmdValid) begin
                    xD     = bus.iX0;
                    x0D    = bus.iX0;
                    x1D    = x1Clamp;
                    yD     = bus.iY0;
                    y1D    = y1Clamp;
                    colorD = bus.iColor;
                    stateD = cmdEmpty ? StSkip : StFill;
                end
            end
            StFill: begin
                wrEn = 1'b1;
                if (xQ == x1Q) begin
                    xD = x0Q;
                    if (yQ == y1Q) begin
                        stateD = StIdle;
                    end else begin
                        yD = yQ + 6'd1;
                    end
                end else begin
                    xD = xQ + 7'd1;
                end
            end
            StSkip: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StClear;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateQ   <= StClear;
            clrAddrQ <= '0;
            xQ       <= '0;
            x0Q      <= '0;
            x1Q      <= '0;
            yQ       <= '0;
            y1Q      <= '0;
            colorQ   <= '0;
        end else begin
            stateQ   <= stateD;
            clrAddrQ <= clrAddrD;
            xQ       <= xD;
            x0Q      <= x0D;
            x1Q      <= x1D;
            yQ       <= yD;
            y1Q      <= y1D;
            colorQ   <= colorD;
        end
    end

    // Read path: stage 1 registers address and in-frame flag, stage 2 is the RAM read
    logic        inFrame;
    logic [12:0] rdAddr;
    logic        inFrameQ;
    logic [12:0] rdAddrQ;
    logic [2:0]  pixelQ;
    logic [5:0]  rowCell;
    logic [6:0]  colCell;

    assign rowCell = bus.iRow[8:3];
    assign colCell = bus.iColumn[9:3];
    assign inFrame = (bus.iColumn < 10'd640) && (bus.iRow < 10'd480);
    assign rdAddr  = 13'({rowCell, 6'b0}) + 13'({rowCell, 4'b0}) + 13'(colCell);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            inFrameQ <= 1'b0;
            rdAddrQ  <= '0;
            pixelQ   <= '0;
        end else begin
            inFrameQ <= inFrame;
            // Blanking addresses can run past the last cell; park them at 0
            rdAddrQ  <= inFrame ? rdAddr : 13'd0;
            pixelQ   <= mem[rdAddrQ] & {3{inFrameQ}};
        end
    end

    assign bus.oPixel = pixelQ;

    // Nonblocking write next to the read gives old data on a same-cycle collision
    always_ff @(posedge Clock) begin
        if (wrEn && !Reset) begin
            mem[wrAddr] <= wrData;
        end
    end
endmodule

// File: tb/tb_vga_rect_fill_buffer.sv
// Directed bench for vga_rect_fill_buffer: busy-cycle counts per command and a pixel
// scoreboard checked against a bench-side cell model.
module tb_vga_rect_fill_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_rect_fill_buffer_if bus ();

    vga_rect_fill_buffer dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [2:0] model [4800];
    logic [2:0] expQ [$];
    string      tagQ [$];
    logic       reqValid = 1'b0;
    logic       v1 = 1'b0;
    logic       v2 = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Read requests reach oPixel two edges after they are sampled
    always @(posedge clk) begin
        v1 <= reqValid;
        v2 <= v1;
    end

    always @(negedge clk) begin
        if (v2) begin
            if (expQ.size() == 0) begin
                check("scoreboard_underflow", 16'd1, 16'd0);
            end else begin
                automatic logic [2:0] e = expQ.pop_front();
                automatic string t = tagQ.pop_front();
                check(t, 16'(bus.oPixel), 16'(e));
            end
        end
    end

    task automatic readAt(input int col, input int row, input logic [2:0] exp);
        bus.iColumn = 10'(col);
        bus.iRow    = 10'(row);
        reqValid    = 1'b1;
        expQ.push_back(exp);
        tagQ.push_back($sformatf("pix(%0d,%0d)", col, row));
        @(negedge clk);
    endtask

    task automatic drain();
        reqValid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic readCell(input int cx, input int cy);
        readAt(cx * 8 + (cx + cy) % 8, cy * 8 + (3 * cx + cy) % 8, model[cy * 80 + cx]);
    endtask

    task automatic scan();
        for (int cy = 0; cy < 60; cy++) begin
            for (int cx = 0; cx < 80; cx++) begin
                readCell(cx, cy);
            end
        end
        drain();
    endtask

    task automatic clearModel();
        for (int i = 0; i < 4800; i++) model[i] = 3'b000;
    endtask

    task automatic setCmd(input int x0, input int y0, input int x1, input int y1,
                          input logic [2:0] color);
        bus.iX0    = 7'(x0);
        bus.iY0    = 6'(y0);
        bus.iX1    = 7'(x1);
        bus.iY1    = 6'(y1);
        bus.iColor = color;
    endtask

    task automatic countBusy(input string tag, input int exp);
        int n = 0;
        while (bus.oBusy && n < 10000) begin
            n++;
            @(negedge clk);
        end
        check(tag, 16'(n), 16'(exp));
    endtask

    // dropAt > 0 issues a competing command on that busy cycle; it must be ignored
    task automatic sendCmd(input string tag, input int x0, input int y0, input int x1,
                           input int y1, input logic [2:0] color, input int dropAt);
        int cx1 = (x1 > 79) ? 79 : x1;
        int cy1 = (y1 > 59) ? 59 : y1;
        bit empty = (x0 > 79) || (y0 > 59) || (x0 > cx1) || (y0 > cy1);
        int expBusy = empty ? 1 : (cx1 - x0 + 1) * (cy1 - y0 + 1);
        int n = 0;
        setCmd(x0, y0, x1, y1, color);
        bus.iCmdValid = 1'b1;
        @(negedge clk);
        bus.iCmdValid = 1'b0;
        while (bus.oBusy && n < 10000) begin
            n++;
            if (n == dropAt) begin
                setCmd(60, 40, 65, 45, 3'b001);
                bus.iCmdValid = 1'b1;
            end else begin
                bus.iCmdValid = 1'b0;
            end
            @(negedge clk);
        end
        bus.iCmdValid = 1'b0;
        check(tag, 16'(n), 16'(expBusy));
        if (!empty) begin
            for (int y = y0; y <= cy1; y++)
                for (int x = x0; x <= cx1; x++)
                    model[y * 80 + x] = color;
        end
    endtask

    initial begin
        bus.iCmdValid = 1'b0;
        setCmd(0, 0, 0, 0, 3'b000);
        bus.iColumn = '0;
        bus.iRow    = '0;
        clearModel();

        // Reset and power-up clear
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 16'(bus.oBusy), 16'd1);
        check("reset_pixel", 16'(bus.oPixel), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        countBusy("clear_busy_cycles", 4800);
        scan();

        // Single cell and its neighbours
        sendCmd("single_busy", 5, 2, 5, 2, 3'b100, 0);
        readAt(40, 16, 3'b100);
        readAt(47, 23, 3'b100);
        readAt(43, 20, 3'b100);
        readAt(39, 16, 3'b000);
        readAt(48, 23, 3'b000);
        readAt(40, 15, 3'b000);
        readAt(47, 24, 3'b000);
        drain();

        // Empty commands, right/bottom clamping, dropped command during a 20-cell fill
        sendCmd("empty_x_busy", 10, 3, 9, 3, 3'b111, 0);
        sendCmd("empty_x0_busy", 80, 0, 85, 5, 3'b111, 0);
        sendCmd("empty_y0_busy", 0, 60, 5, 63, 3'b111, 0);
        sendCmd("clamp_busy", 75, 57, 90, 59, 3'b101, 0);
        sendCmd("drop_busy", 20, 20, 39, 20, 3'b110, 5);
        scan();

        // Collision: RAM read of cell (30,30) on the same edge as its write
        setCmd(30, 30, 30, 30, 3'b111);
        bus.iCmdValid = 1'b1;
        readAt(240, 240, 3'b000);
        bus.iCmdValid = 1'b0;
        readAt(241, 243, 3'b111);
        reqValid = 1'b0;
        countBusy("collision_settle", 0);
        model[30 * 80 + 30] = 3'b111;
        drain();

        // Full-screen fill with both corners clamped
        sendCmd("full_busy", 0, 0, 100, 63, 3'b010, 0);
        scan();
        readAt(700, 100, 3'b000);
        readAt(100, 480, 3'b000);
        readAt(639, 479, 3'b010);
        drain();

        // Reset on the 7th write of a 60-cell fill, with a command held during reset
        setCmd(0, 0, 9, 5, 3'b011);
        bus.iCmdValid = 1'b1;
        @(negedge clk);
        bus.iCmdValid = 1'b0;
        check("midfill_busy", 16'(bus.oBusy), 16'd1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        setCmd(0, 0, 79, 59, 3'b101);
        bus.iCmdValid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midfill_reset_busy", 16'(bus.oBusy), 16'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.iCmdValid = 1'b0;
        countBusy("midfill_clear_cycles", 4800);
        clearModel();
        scan();

        begin
            int guard = 0;
            while (expQ.size() != 0 && guard < 20) begin
                guard++;
                @(negedge clk);
            end
            check("scoreboard_drained", 16'(expQ.size()), 16'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
